// File: rtl/xor_stream_cipher_mch.sv
// Multi-channel XOR stream cipher: per-channel Galois LFSR keystream, serial config chain,
// 1-cycle registered valid/ready output per channel; cfg_en and ld stall accepts, drains continue.
module xor_stream_cipher_mch #(
    parameter int           M        = 32,
    parameter int           W        = 8,
    parameter int           NCH      = 2,
    parameter logic [M-1:0] DEF_TAPS = 32'h48000000,
    parameter logic [M-1:0] DEF_SEED = 32'h00000055
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_i,
    output logic             cfg_o,
    output logic             ld,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [NCH*W-1:0] out_data,
    output logic [NCH-1:0]   zero_err
);

    localparam int L  = NCH * 2 * M;
    localparam int CW = $clog2(L + 1);

    logic [L-1:0]  cfg_reg;
    logic [CW-1:0] cnt;

    assign cfg_o = cfg_en & cfg_reg[0];

    // Only a complete run of L consecutive shifts arms a reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_reg <= {NCH{DEF_TAPS, DEF_SEED}};
            cnt     <= '0;
            ld      <= 1'b0;
        end else begin
            ld <= 1'b0;
            if (cfg_en) begin
                cfg_reg <= {cfg_i, cfg_reg[L-1:1]};
                if (cnt == CW'(L - 1)) begin
                    cnt <= '0;
                    ld  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [M-1:0] lfsr;
        logic [M-1:0] taps;
        logic [M-1:0] s_nxt;
        logic [W-1:0] ks;
        logic [W-1:0] dat;
        logic         vld;
        logic         zq;
        logic         acc;

        assign in_ready[c]          = !cfg_en & !ld & (!vld | out_ready[c]);
        assign acc                  = in_valid[c] & in_ready[c];
        assign out_valid[c]         = vld;
        assign out_data[c*W +: W]   = dat;
        assign zero_err[c]          = zq;

        always_comb begin
            s_nxt = lfsr;
            ks    = '0;
            for (int i = 0; i < W; i++) begin
                ks[i] = s_nxt[0];
                s_nxt = (s_nxt >> 1) ^ (s_nxt[0] ? taps : '0);
            end
        end

        // Taps are captured together with the seed so a partial shift cannot disturb a running stream.
        always_ff @(posedge clk) begin
            if (rst) begin
                lfsr <= DEF_SEED;
                taps <= DEF_TAPS;
                vld  <= 1'b0;
                dat  <= '0;
                zq   <= 1'b0;
            end else begin
                if (ld) begin
                    lfsr <= cfg_reg[c*2*M +: M];
                    taps <= cfg_reg[c*2*M+M +: M];
                    zq   <= (cfg_reg[c*2*M +: M] == '0);
                end else if (acc) begin
                    lfsr <= s_nxt;
                    zq   <= (s_nxt == '0);
                end
                if (acc) begin
                    dat <= in_data[c*W +: W] ^ ks;
                    vld <= 1'b1;
                end else if (out_ready[c]) begin
                    vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_cipher_mch.sv
// Directed bench: reset, keystream vectors, loopback decrypt, config reload, backpressure, zero seed, reset.
module tb_xor_stream_cipher_mch;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic        cfg_i;
    logic        cfg_o;
    logic        ld;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [15:0] in_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [15:0] out_data;
    logic [1:0]  zero_err;
    logic        rdy0;

    logic        b_cfg_o;
    logic        b_ld;
    logic [1:0]  b_in_valid;
    logic [1:0]  b_in_ready;
    logic [15:0] b_in_data;
    logic [1:0]  b_out_valid;
    logic [15:0] b_out_data;
    logic [1:0]  b_zero_err;

    int total = 0;
    int bad   = 0;

    assign out_ready  = {b_in_ready[1], rdy0};
    assign b_in_valid = {out_valid[1], 1'b0};
    assign b_in_data  = {out_data[15:8], 8'h00};

    xor_stream_cipher_mch dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o), .ld(ld),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .zero_err(zero_err)
    );

    xor_stream_cipher_mch dut_b (
        .clk(clk), .rst(rst), .cfg_en(1'b0), .cfg_i(1'b0), .cfg_o(b_cfg_o), .ld(b_ld),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(2'b11), .out_data(b_out_data), .zero_err(b_zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [127:0] old_chain;
        logic [127:0] new_chain;
        logic [7:0]   q[$];
        logic [7:0]   b;
        int           sent;
        int           got;
        int           ld_hits;

        old_chain = {32'h48000000, 32'h00000055, 32'h48000000, 32'h00000055};
        new_chain = {32'h48000000, 32'h00000000, 32'h48000000, 32'h000000A3};

        rst = 1'b1; cfg_en = 1'b0; cfg_i = 1'b0;
        in_valid = 2'b00; in_data = 16'h0000; rdy0 = 1'b1;
        tick(); tick(); tick();
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_ld", ld, 1'b0);
        chk("rst_cfg_o", cfg_o, 1'b0);
        chk("rst_zero_err", zero_err, 2'b00);
        rst = 1'b0;
        tick();

        // T1: default seed gives 0x55 then 0x00
        in_valid[0] = 1'b1; in_data[7:0] = 8'h00;
        tick();
        chk("t1_valid", out_valid[0], 1'b1);
        chk("t1_beat0", out_data[7:0], 8'h55);
        tick();
        chk("t1_beat1", out_data[7:0], 8'h00);
        in_valid[0] = 1'b0;
        tick();
        chk("t1_drain", out_valid[0], 1'b0);

        // T2: ch1 encrypted by dut, decrypted by dut_b
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                b = 8'($urandom);
                in_valid[1] = 1'b1; in_data[15:8] = b;
                q.push_back(b); sent++;
            end else begin
                in_valid[1] = 1'b0;
            end
            tick();
            if (b_out_valid[1]) begin
                if (q.size() == 0) chk("t2_spurious", 1, 0);
                else chk("t2_byte", b_out_data[15:8], q.pop_front());
                got++;
            end
        end
        in_valid[1] = 1'b0;
        chk("t2_count", got, 1000);
        tick();

        // T5: stall on ch0, then release for back-to-back beats
        rdy0 = 1'b0; in_valid[0] = 1'b1; in_data[7:0] = 8'h3C;
        tick();
        chk("t5_valid", out_valid[0], 1'b1);
        chk("t5_first", out_data[7:0], 8'h3C);
        chk("t5_not_ready", in_ready[0], 1'b0);
        in_data[7:0] = 8'h11;
        tick();
        chk("t5_hold_data", out_data[7:0], 8'h3C);
        chk("t5_hold_valid", out_valid[0], 1'b1);
        rdy0 = 1'b1;
        #1;
        chk("t5_ready_back", in_ready[0], 1'b1);
        tick();
        chk("t5_b2b_0", out_data[7:0], 8'hC1);
        in_data[7:0] = 8'h00;
        tick();
        chk("t5_b2b_1", out_data[7:0], 8'h2F);
        chk("t5_b2b_valid", out_valid[0], 1'b1);
        in_valid[0] = 1'b0;
        tick();
        chk("t5_drain", out_valid[0], 1'b0);

        // T3: full reload, ch0 seed 0xA3, ch1 seed 0
        ld_hits = 0;
        for (int j = 0; j < 128; j++) begin
            cfg_en = 1'b1; cfg_i = new_chain[j];
            #1;
            chk("t3_cfg_o", cfg_o, old_chain[j]);
            tick();
            if (j < 127 && ld) ld_hits++;
        end
        chk("t3_early_ld", ld_hits, 0);
        chk("t3_ld_pulse", ld, 1'b1);
        cfg_en = 1'b0;
        #1;
        chk("t3_ready_ld", in_ready[0], 1'b0);
        tick();
        chk("t3_ld_single", ld, 1'b0);
        chk("t6_zero_err", zero_err, 2'b10);
        in_valid = 2'b11; in_data = 16'h5A00;
        tick();
        chk("t3_new_seed", out_data[7:0], 8'hA3);
        chk("t6_passthru", out_data[15:8], 8'h5A);
        in_valid = 2'b00;
        tick();

        // T4: partial shift must not reload
        ld_hits = 0;
        for (int j = 0; j < 100; j++) begin
            cfg_en = 1'b1; cfg_i = 1'b0;
            tick();
            if (ld) ld_hits++;
        end
        cfg_en = 1'b0;
        tick();
        if (ld) ld_hits++;
        chk("t4_no_ld", ld_hits, 0);
        in_valid[0] = 1'b1; in_data[7:0] = 8'h00;
        tick();
        chk("t4_beat0", out_data[7:0], 8'h00);
        tick();
        chk("t4_beat1", out_data[7:0], 8'h00);
        tick();
        chk("t4_beat2", out_data[7:0], 8'hB0);
        in_valid[0] = 1'b0;
        tick();

        // T6: reset with a pending beat and a shift in progress
        rdy0 = 1'b0; in_valid[0] = 1'b1; in_data[7:0] = 8'h77;
        tick();
        cfg_en = 1'b1; cfg_i = 1'b1;
        tick();
        rst = 1'b1; cfg_en = 1'b0; in_valid = 2'b00;
        tick();
        chk("t6_rst_valid", out_valid, 2'b00);
        chk("t6_rst_data", out_data, 16'h0000);
        chk("t6_rst_ld", ld, 1'b0);
        chk("t6_rst_zero_err", zero_err, 2'b00);
        chk("t6_rst_cfg_o", cfg_o, 1'b0);
        rst = 1'b0; rdy0 = 1'b1;
        tick();
        in_valid[0] = 1'b1; in_data[7:0] = 8'h00;
        tick();
        chk("t6_seed_back", out_data[7:0], 8'h55);
        in_valid[0] = 1'b0;
        cfg_en = 1'b1; cfg_i = 1'b0;
        #1;
        chk("t6_chain_bit0", cfg_o, 1'b1);
        tick();
        chk("t6_chain_bit1", cfg_o, 1'b0);
        cfg_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
